fifo_wptr_full_ctrl: RTL and testbench
======================================

// Module: fifo_wptr_full_ctrl
// PURPOSE
//  Write-side controller of the async FIFO, in the write clock domain.
//  - Accepts push requests and drives the dual-port RAM write port.
//  - Keeps the binary and Gray write pointers.
//  - Takes the Gray read pointer after its 2-flop write-domain synchronizer.
//  - Produces full, almost-full, a conservative fill level and a sticky overflow error.
//  - Its Gray write pointer feeds the read-domain synchronizer.
// PARAMETERS
//  ADDR_BITS    4  RAM address width; depth = 2**ADDR_BITS; pointers are ADDR_BITS+1 wide; min 2
//  AF_MARGIN    2  w_almost_full asserts when w_level >= 2**ADDR_BITS - AF_MARGIN; range 1..depth
//  STOP_ON_OVF  1  1: after an overflow, refuse all writes until w_err_clr; 0: keep running
// PORTS
//  w_clk          in   1            write-domain clock
//  w_rst          in   1            synchronous, active-high reset
//  w_en           in   1            push request this cycle; data is carried on the RAM data path outside this block
//  w_err_clr      in   1            clears w_overflow; leaves HOLD
//  ff2_r_ptr      in   ADDR_BITS+1  Gray read pointer, already synchronized into w_clk
//  w_ptr          out  ADDR_BITS+1  Gray write pointer, registered; to read-side synchronizer
//  w_addr         out  ADDR_BITS    RAM write address = binary write pointer LSBs
//  mem_we         out  1            RAM write strobe
//  w_full         out  1            FIFO full, registered
//  w_almost_full  out  1            level threshold reached, registered
//  w_level        out  ADDR_BITS+1  occupancy 0..2**ADDR_BITS as seen by the write side, registered
//  w_overflow     out  1            sticky: a push was dropped
// BEHAVIOUR
//  Reset (w_rst=1 at posedge)
//   - Binary and Gray write pointers := 0; state := RUN.
//   - w_full=0, w_almost_full=0, w_level=0, w_overflow=0, mem_we=0.
//   - Reset takes priority over every input.
//   - System rule: the read side is reset in the same window. Reset mid-operation discards the contents.
//  Accept
//   - accept = w_en & ~w_full & (state!=HOLD); combinational.
//   - mem_we = accept. w_addr is always the current binary pointer.
//   - On accept the binary pointer increments at the next edge and wraps mod 2**(ADDR_BITS+1).
//   - w_ptr = bin2gray(next binary pointer), registered in the same edge.
//  Flags and level
//   - Full: computed from the next Gray pointer and registered.
//     w_full_next = (gray_next == {~ff2_r_ptr[MSB:MSB-1], ff2_r_ptr[MSB-2:0]}).
//     w_full is high the cycle after the write that fills the FIFO.
//   - Level: rbin = gray2bin(ff2_r_ptr); w_level = (wbin_next - rbin), ADDR_BITS+1 bits, modulo arithmetic.
//     Pessimistic by the synchronizer latency; it never under-reports.
//   - Almost full: w_almost_full = (w_level_next >= 2**ADDR_BITS - AF_MARGIN), registered.
//  Overflow
//   - drop = w_en & ~accept.
//   - A drop sets w_overflow at the next edge. The pointer does not move; mem_we stays 0.
//  w_err_clr
//   - Clears w_overflow at the next edge.
//   - Same cycle as a drop: the set wins.
//  FSM
//   - RUN  -> FULL when w_full_next; -> HOLD when drop & STOP_ON_OVF.
//   - FULL -> RUN when ~w_full_next; -> HOLD when drop & STOP_ON_OVF.
//   - HOLD -> RUN when w_err_clr & ~w_full_next; -> FULL when w_err_clr & w_full_next.
//   - In HOLD no write is accepted. A w_en in HOLD is a drop and keeps w_overflow set.
//   - With STOP_ON_OVF=0, HOLD is never entered.
//  Simultaneous events
//   - Read pointer advances in the same cycle as a write into the last slot: full is judged on the synchronized pointer only.
//     Full may be reported one or two extra cycles. This is correct, conservative behaviour.
//  Wrap
//   - The pointer MSB toggles each lap.
//   - Full and level are correct across any number of laps.
// STRUCTURE
//  - Shared include fifo_defs.vh holds:
//    - bin2gray and gray2bin functions (reused by the read-side controller);
//    - FSM state localparams RUN=2'd0, FULL=2'd1, HOLD=2'd2.
//  - One sub-module, fifo_gray2bin (parameterised width, combinational XOR prefix), converts ff2_r_ptr.
//  - Everything else is flat in this module.
// TESTING (ADDR_BITS=4, AF_MARGIN=2, ff2_r_ptr held at 0 unless stated)
//  1 Reset, then 16 pushes:
//    - mem_we high on all 16; w_addr 0..15.
//    - w_almost_full=1 after push 14.
//    - w_full=1 and w_level=16 after push 16.
//    - w_ptr=5'b11000 after push 16.
//  2 Full, then push:
//    - mem_we=0, pointer unchanged; w_overflow=1 next cycle; state HOLD.
//    - Then drive ff2_r_ptr=gray(4): w_full stays 1 through the pending-flag path until w_err_clr.
//    - After w_err_clr the next push is accepted at w_addr=0.
//  3 STOP_ON_OVF=0, same as 2:
//    - w_overflow=1, state never HOLD.
//    - After ff2_r_ptr=gray(1), w_full=0 and the next push is accepted.
//  4 Wrap: 40 pushes with ff2_r_ptr tracking the write pointer 3 cycles late:
//    - no drops; w_level never exceeds 16;
//    - w_ptr returns to gray(40 mod 32)=gray(8).
//  5 Drop and w_err_clr in the same cycle: w_overflow=1 afterwards.
//  6 Reset asserted mid-burst at pointer 9: next cycle all outputs are at reset values and w_addr=0.

Source files
------------

// File: rtl/fifo_wptr_full_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wptr_full_ctrl_pkg
// Brief    : Shared write-side FIFO controller types (FSM state encoding).
// Revision : 1.0 - initial release
// ============================================================================
package fifo_wptr_full_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        FULL = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_gray2bin.sv
`default_nettype none
// ============================================================================
// Module   : fifo_gray2bin
// Brief    : Combinational Gray-to-binary converter (XOR prefix from the MSB).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Each binary bit is the parity of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_xor
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wptr_full_ctrl
// Brief    : Async FIFO write-side controller: pointers, full/almost-full,
//            conservative fill level and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wptr_full_ctrl
    import fifo_wptr_full_ctrl_pkg::*;
#(
    parameter int ADDR_BITS   = 4,
    parameter int AF_MARGIN   = 2,
    parameter bit STOP_ON_OVF = 1'b1
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    input  logic                 w_en,
    input  logic                 w_err_clr,
    input  logic [ADDR_BITS:0]   ff2_r_ptr,
    output logic [ADDR_BITS:0]   w_ptr,
    output logic [ADDR_BITS-1:0] w_addr,
    output logic                 mem_we,
    output logic                 w_full,
    output logic                 w_almost_full,
    output logic [ADDR_BITS:0]   w_level,
    output logic                 w_overflow
);

    localparam int PTR_W = ADDR_BITS + 1;
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [PTR_W-1:0] c_af_thresh = PTR_W'(DEPTH - AF_MARGIN);

    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] gray_q, gray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    state_e           state_q, state_d;

    logic [PTR_W-1:0] w_rbin;
    logic [PTR_W-1:0] w_full_cmp;
    logic             w_accept;
    logic             w_drop;
    logic             w_full_next;

    fifo_gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .i_gray (ff2_r_ptr),
        .o_bin  (w_rbin)
    );

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign w_full_cmp = {~ff2_r_ptr[PTR_W-1 -: 2], ff2_r_ptr[PTR_W-3:0]};

    always_comb begin
        w_accept    = w_en & ~full_q & (state_q != HOLD) & ~w_rst;
        w_drop      = w_en & ~w_accept;
        wbin_d      = wbin_q + PTR_W'(w_accept);
        gray_d      = wbin_d ^ (wbin_d >> 1);
        w_full_next = (gray_d == w_full_cmp);
        level_d     = wbin_d - w_rbin;
        af_d        = (level_d >= c_af_thresh);
        ovf_d       = w_drop | (ovf_q & ~w_err_clr);
        // While held, full stays frozen until software acknowledges the error.
        full_d      = ((state_q == HOLD) && !w_err_clr) ? full_q : w_full_next;

        state_d = state_q;
        case (state_q)
            RUN: begin
                if (w_drop && STOP_ON_OVF) state_d = HOLD;
                else if (w_full_next)      state_d = FULL;
            end
            FULL: begin
                if (w_drop && STOP_ON_OVF) state_d = HOLD;
                else if (!w_full_next)     state_d = RUN;
            end
            HOLD: begin
                if (w_err_clr) state_d = w_full_next ? FULL : RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= RUN;
        end else begin
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign w_ptr         = gray_q;
    assign w_addr        = wbin_q[ADDR_BITS-1:0];
    assign mem_we        = w_accept;
    assign w_full        = full_q;
    assign w_almost_full = af_q;
    assign w_level       = level_q;
    assign w_overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wptr_full_ctrl
// Brief    : Bench for two controller instances (STOP_ON_OVF=1 and 0) against
//            a count-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wptr_full_ctrl;

    logic       clk = 1'b0;
    logic       w_rst, w_en, w_err_clr;
    logic [4:0] rptr    [2];
    logic [4:0] o_ptr   [2];
    logic [4:0] o_level [2];
    logic [3:0] o_addr  [2];
    logic       o_we    [2];
    logic       o_full  [2];
    logic       o_af    [2];
    logic       o_ovf   [2];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Model: instance 0 stops on overflow, instance 1 keeps running.
    int wcnt [2];
    int rd   [2];
    int mlvl [2];
    bit mfull[2], maf[2], movf[2], mhold[2];

    always #5 clk = ~clk;

    fifo_wptr_full_ctrl #(.ADDR_BITS(4), .AF_MARGIN(2), .STOP_ON_OVF(1'b1)) dut_stop (
        .w_clk(clk), .w_rst(w_rst), .w_en(w_en), .w_err_clr(w_err_clr),
        .ff2_r_ptr(rptr[0]), .w_ptr(o_ptr[0]), .w_addr(o_addr[0]), .mem_we(o_we[0]),
        .w_full(o_full[0]), .w_almost_full(o_af[0]), .w_level(o_level[0]),
        .w_overflow(o_ovf[0])
    );

    fifo_wptr_full_ctrl #(.ADDR_BITS(4), .AF_MARGIN(2), .STOP_ON_OVF(1'b0)) dut_run (
        .w_clk(clk), .w_rst(w_rst), .w_en(w_en), .w_err_clr(w_err_clr),
        .ff2_r_ptr(rptr[1]), .w_ptr(o_ptr[1]), .w_addr(o_addr[1]), .mem_we(o_we[1]),
        .w_full(o_full[1]), .w_almost_full(o_af[1]), .w_level(o_level[1]),
        .w_overflow(o_ovf[1])
    );

    function automatic logic [4:0] gray5(input int n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        wcnt[k] = 0; rd[k] = 0; mlvl[k] = 0;
        mfull[k] = 0; maf[k] = 0; movf[k] = 0; mhold[k] = 0;
    endtask

    // One clock: drive read pointers, check all outputs, advance the model.
    task automatic step();
        for (int k = 0; k < 2; k++) rptr[k] = gray5(rd[k]);
        #2;
        for (int k = 0; k < 2; k++) begin
            bit acc, drop;
            int wn, lvl;
            acc = w_en && !mfull[k] && !mhold[k] && !w_rst;
            chk("mem_we", k, 32'(o_we[k]), 32'(acc));
            chk("w_addr", k, 32'(o_addr[k]), wcnt[k] % 16);
            chk("w_ptr", k, 32'(o_ptr[k]), 32'(gray5(wcnt[k])));
            chk("w_full", k, 32'(o_full[k]), 32'(mfull[k]));
            chk("w_almost_full", k, 32'(o_af[k]), 32'(maf[k]));
            chk("w_level", k, 32'(o_level[k]), mlvl[k]);
            chk("w_overflow", k, 32'(o_ovf[k]), 32'(movf[k]));
            if (w_rst) begin
                model_reset(k);
            end else begin
                drop = w_en && !acc;
                wn   = wcnt[k] + int'(acc);
                lvl  = wn - rd[k];
                if (!(mhold[k] && !w_err_clr)) mfull[k] = (lvl == 16);
                maf[k]  = (lvl >= 14);
                mlvl[k] = lvl;
                wcnt[k] = wn;
                movf[k] = drop || (movf[k] && !w_err_clr);
                if (k == 0) mhold[k] = mhold[k] ? !w_err_clr : drop;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        w_rst = 1'b1; w_en = 1'b0; w_err_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            rptr[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        step();

        // Fill to full with the reader idle.
        w_rst = 1'b0; w_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 13) chk("af_before_14", 0, 32'(o_af[0]), 32'd0);
            if (i == 14) chk("af_after_14", 0, 32'(o_af[0]), 32'd1);
        end
        chk("full_after_16", 0, 32'(o_full[0]), 32'd1);
        chk("level_after_16", 0, 32'(o_level[0]), 32'd16);
        chk("ptr_after_16", 0, 32'(o_ptr[0]), 32'b11000);

        // Push into a full FIFO.
        step();
        chk("ovf_stop", 0, 32'(o_ovf[0]), 32'd1);
        chk("ovf_run", 1, 32'(o_ovf[1]), 32'd1);
        w_en = 1'b0; rd[0] = 4; rd[1] = 1;
        step();
        chk("full_frozen_hold", 0, 32'(o_full[0]), 32'd1);
        chk("full_clears_run", 1, 32'(o_full[1]), 32'd0);
        w_en = 1'b1;
        step();
        w_en = 1'b0; w_err_clr = 1'b1;
        step();
        w_err_clr = 1'b0;
        step();
        w_en = 1'b1;
        #2;
        chk("addr_after_clr", 0, 32'(o_addr[0]), 32'd0);
        chk("we_after_clr", 0, 32'(o_we[0]), 32'd1);
        step();

        // Refill, then drop together with w_err_clr.
        repeat (5) step();
        w_err_clr = 1'b1;
        step();
        chk("ovf_set_wins", 0, 32'(o_ovf[0]), 32'd1);
        chk("ovf_set_wins", 1, 32'(o_ovf[1]), 32'd1);
        w_en = 1'b0;
        step();
        w_err_clr = 1'b0;

        // Wrap: 40 pushes, reader three pushes behind.
        w_rst = 1'b1;
        step();
        w_rst = 1'b0; w_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++) rd[k] = (wcnt[k] > 3) ? wcnt[k] - 3 : 0;
            step();
        end
        chk("wrap_ptr", 0, 32'(o_ptr[0]), 32'b01100);
        chk("wrap_ptr", 1, 32'(o_ptr[1]), 32'b01100);
        chk("wrap_no_ovf", 0, 32'(o_ovf[0]), 32'd0);
        w_en = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            w_en      = ($urandom_range(99) < 65);
            w_err_clr = ($urandom_range(99) < 6);
            w_rst     = ($urandom_range(199) == 0);
            for (int k = 0; k < 2; k++)
                if (rd[k] < wcnt[k] && $urandom_range(99) < 50) rd[k]++;
            step();
        end
        w_rst = 1'b0; w_err_clr = 1'b0; w_en = 1'b0;

        // Reset in the middle of a burst.
        w_rst = 1'b1;
        step();
        w_rst = 1'b0; w_en = 1'b1;
        repeat (9) step();
        w_rst = 1'b1;
        #2;
        chk("addr_before_rst", 0, 32'(o_addr[0]), 32'd9);
        step();
        w_rst = 1'b0; w_en = 1'b0;
        #2;
        chk("rst_addr", 0, 32'(o_addr[0]), 32'd0);
        chk("rst_ptr", 0, 32'(o_ptr[0]), 32'd0);
        chk("rst_level", 0, 32'(o_level[0]), 32'd0);
        chk("rst_full", 0, 32'(o_full[0]), 32'd0);
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
